dram_arbiter: RTL and testbench

//  Shares the single-port data RAM (dram: async read, sync write, 14-bit word addr) between
//  the single-cycle CPU load/store path and one external requester (loader/debug master).
//  CPU has priority; the ext port gets a forced grant after MAX_WAIT blocked cycles, and the
//  CPU is then stalled for that cycle (PC hold + RF write inhibit in top).

---
 rtl/dram_arbiter.sv | 122 ++++++++++++
 tb/tb_dram_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the CPU load/store
// path (priority) and one external requester. The ext port is force-granted
// after MAX_WAIT consecutive blocked cycles, stalling the CPU for that cycle.
// Optional build macro DRAM_ARB_PERF_EN adds 16-bit saturating perf counters.
module dram_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_ack,
    output logic [DW-1:0] ext_rdata,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_d,
    input  logic [DW-1:0] mem_spo,
    output logic [15:0]   perf_stall,
    output logic [15:0]   perf_ext
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          we;
        logic [DW-1:0] d;
    } mem_req_t;

    localparam logic [7:0] WMAX = 8'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [7:0] wcnt;
    logic       grant_ext;
    mem_req_t   cpu_side, ext_side, sel;

    // ACK is a one-cycle turnaround: ext_req is ignored there so a held
    // request cannot be granted twice in a row.
    always_comb begin
        grant_ext = ext_req && (state != S_ACK) && (!cpu_req || wcnt == WMAX);
        cpu_side  = {cpu_addr, cpu_we & cpu_req, cpu_wdata};
        ext_side  = {ext_addr, ext_we, ext_wdata};
        sel       = grant_ext ? ext_side : cpu_side;
        mem_a     = sel.a;
        mem_we    = sel.we & rst_n;
        mem_d     = sel.d;
        cpu_rdata = mem_spo;
        cpu_stall = cpu_req & grant_ext;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_WAIT: begin
                if (grant_ext)    state_nxt = S_ACK;
                else if (ext_req) state_nxt = S_WAIT;
                else              state_nxt = S_IDLE;
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Blocked-cycle counter; any grant, ACK or dropped request clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wcnt <= '0;
        else if (state != S_ACK && ext_req && !grant_ext)
            wcnt <= (wcnt == WMAX) ? wcnt : wcnt + 8'd1;
        else
            wcnt <= '0;
    end

    // Ack pulse and read capture; a granted write returns the pre-write data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_ack   <= 1'b0;
            ext_rdata <= '0;
        end else begin
            ext_ack <= grant_ext;
            if (grant_ext) ext_rdata <= mem_spo;
        end
    end

`ifdef DRAM_ARB_PERF_EN
    logic [15:0] pstall_q, pext_q;

    // Saturating stall / ext-grant counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstall_q <= '0;
            pext_q   <= '0;
        end else begin
            if (cpu_stall && pstall_q != 16'hFFFF) pstall_q <= pstall_q + 16'd1;
            if (grant_ext && pext_q   != 16'hFFFF) pext_q   <= pext_q + 16'd1;
        end
    end

    assign perf_stall = pstall_q;
    assign perf_ext   = pext_q;
`else
    assign perf_stall = 16'h0;
    assign perf_ext   = 16'h0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural arbitration model and a shadow memory.
module tb_dram_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;
`ifdef DRAM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          ext_req = 1'b0, ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic          ext_ack;
    logic [DW-1:0] ext_rdata;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_spo;
    logic [15:0]   perf_stall, perf_ext;

    dram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d), .mem_spo(mem_spo),
        .perf_stall(perf_stall), .perf_ext(perf_ext)
    );

    always #5 clk = ~clk;

    // DRAM: async read, sync write
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) if (mem_we) ram[mem_a] <= mem_d;
    assign mem_spo = ram[mem_a];

    // reference model state
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            blocked, n_stall, n_ext;
    bit            gr_last, m_ack;
    logic [DW-1:0] m_rdata;
    bit            saw_ack, saw_stall, prev_ack;
    logic [DW-1:0] saw_rdata;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pexp(input int n);
        return PERF ? ((n > 65535) ? 16'hFFFF : 16'(n)) : 16'h0;
    endfunction

    task automatic model_clear();
        blocked = 0; n_stall = 0; n_ext = 0;
        gr_last = 0; m_ack = 0; m_rdata = '0; prev_ack = 0;
    endtask

    // One clock: check outputs at negedge, advance model at posedge, return at posedge+1.
    task automatic cycle();
        bit g;
        @(negedge clk);
        g = ext_req && !gr_last && (!cpu_req || blocked >= MAX_WAIT);
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && g));
        chk("mem_we", 32'(mem_we), 32'(g ? ext_we : (cpu_req && cpu_we)));
        chk("mem_a", 32'(mem_a), 32'(g ? ext_addr : cpu_addr));
        chk("mem_d", mem_d, g ? ext_wdata : cpu_wdata);
        chk("cpu_rdata", cpu_rdata, ref_mem[g ? ext_addr : cpu_addr]);
        chk("ext_ack", 32'(ext_ack), 32'(m_ack));
        chk("ext_rdata", ext_rdata, m_rdata);
        chk("ack_gap", 32'(ext_ack && prev_ack), 32'd0);
        chk("perf_stall", 32'(perf_stall), 32'(pexp(n_stall)));
        chk("perf_ext", 32'(perf_ext), 32'(pexp(n_ext)));
        saw_ack = ext_ack; saw_stall = cpu_stall; saw_rdata = ext_rdata;
        prev_ack = ext_ack;
        @(posedge clk);
        if (g) begin
            m_rdata = ref_mem[ext_addr];
            if (ext_we) ref_mem[ext_addr] = ext_wdata;
            m_ack = 1; gr_last = 1; blocked = 0;
            n_ext++;
            if (cpu_req) n_stall++;
        end else begin
            if (cpu_req && cpu_we) ref_mem[cpu_addr] = cpu_wdata;
            if (!gr_last && ext_req) blocked = (blocked >= MAX_WAIT) ? MAX_WAIT : blocked + 1;
            else blocked = 0;
            m_ack = 0; gr_last = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_ack", 32'(ext_ack), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_rdata", ext_rdata, 32'd0);
        chk("rst_pstall", 32'(perf_stall), 32'd0);
        chk("rst_pext", 32'(perf_ext), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_cpu(input bit r, input bit w, input int a, input logic [31:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = AW'(a); cpu_wdata = d;
    endtask

    task automatic set_ext(input bit r, input bit w, input int a, input logic [31:0] d);
        ext_req = r; ext_we = w; ext_addr = AW'(a); ext_wdata = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls, stall_at, got_ack;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = 32'(i) * 32'h9E3779B1;
            ref_mem[i] = ram[i];
        end
        ram[14'h10] = 32'hDEADBEEF;
        ref_mem[14'h10] = 32'hDEADBEEF;

        @(posedge clk);
        do_reset();

        // 1: ext read with idle CPU
        set_ext(1, 0, 'h10, 0);
        cycle();
        chk("t1_stall", 32'(saw_stall), 32'd0);
        cycle();
        chk("t1_ack", 32'(saw_ack), 32'd1);
        chk("t1_rdata", saw_rdata, 32'hDEADBEEF);
        set_ext(0, 0, 0, 0);
        cycle();

        // 2 / 6: starvation, repeated ten times from a fresh reset
        do_reset();
        for (int r = 0; r < 10; r++) begin
            set_cpu(1, 1, 'h21 + r, 32'hC0 + 32'(r));
            set_ext(1, 1, 'h20, 32'h55);
            stalls = 0; stall_at = -1; got_ack = 0;
            for (int i = 0; i < 12 && !got_ack; i++) begin
                cycle();
                if (saw_stall) begin stalls++; stall_at = i; end
                got_ack = saw_ack;
            end
            chk("t2_ack", 32'(got_ack), 32'd1);
            chk("t2_stalls", 32'(stalls), 32'd1);
            chk("t2_stall_at", 32'(stall_at), 32'(MAX_WAIT));
            set_ext(0, 0, 0, 0);
            set_cpu(0, 0, 0, 0);
            cycle();
        end
        chk("t2_mem", ram[14'h20], 32'h55);
        chk("t6_pstall", 32'(perf_stall), PERF ? 32'd10 : 32'd0);
        chk("t6_pext", 32'(perf_ext), PERF ? 32'd10 : 32'd0);

        // 3: simultaneous CPU store and ext write to the same word
        set_cpu(1, 1, 'h30, 32'h11);
        set_ext(1, 1, 'h30, 32'h22);
        cycle();
        chk("t3_cpu_first", 32'(saw_stall), 32'd0);
        set_cpu(0, 0, 0, 0);
        got_ack = 0;
        for (int i = 0; i < 8 && !got_ack; i++) begin cycle(); got_ack = saw_ack; end
        chk("t3_ack", 32'(got_ack), 32'd1);
        set_ext(0, 0, 0, 0);
        cycle();
        chk("t3_mem", ram[14'h30], 32'h22);

        // 4: ext_req held through ack, back-to-back grants
        set_ext(1, 0, 'h40, 0);
        repeat (8) cycle();
        set_ext(0, 0, 0, 0);
        cycle();

        // 5: reset while waiting with wcnt=3
        set_cpu(1, 1, 'h50, 32'hAA);
        set_ext(1, 1, 'h51, 32'hBB);
        repeat (3) cycle();
        do_reset();
        set_cpu(0, 0, 0, 0);
        set_ext(0, 0, 0, 0);
        repeat (2) cycle();
        set_cpu(1, 0, 'h52, 0);
        set_ext(1, 0, 'h53, 0);
        stall_at = -1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (saw_stall && stall_at < 0) stall_at = i;
        end
        chk("t5_stall_at", 32'(stall_at), 32'(MAX_WAIT));
        set_ext(0, 0, 0, 0);
        set_cpu(0, 0, 0, 0);
        cycle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_cpu(($urandom % 4) != 0, $urandom % 2, $urandom % 64, $urandom);
            if (!ext_req && ($urandom % 3) == 0)
                set_ext(1, $urandom % 2, $urandom % 64, $urandom);
            cycle();
            if (saw_ack) begin
                if (($urandom % 4) == 0) set_ext(1, $urandom % 2, $urandom % 64, $urandom);
                else ext_req = 1'b0;
            end else if (ext_req && ($urandom % 50) == 0) begin
                ext_req = 1'b0;
            end
        end
        set_cpu(0, 0, 0, 0);
        set_ext(0, 0, 0, 0);
        repeat (2) cycle();
        for (int i = 0; i < 64; i++) chk("final_mem", ram[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
